// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a req/ack data-memory handshake and stalls the front end until the access completes.
// Optional access watchdog is built only when MEM_TIMEOUT_EN is defined.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] alu_result_in,
  input  logic [7:0] write_data_in,
  input  logic [2:0] rd_in,
  input  logic       mem_read_in,
  input  logic       mem_write_in,
  input  logic       reg_write_in,
  input  logic       mem_to_reg_in,
  output logic       stall_out,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic [7:0] dmem_addr,
  output logic [7:0] dmem_wdata,
  input  logic       dmem_ack,
  input  logic [7:0] dmem_rdata,
  output logic [7:0] alu_result_out,
  output logic [7:0] read_data_out,
  output logic [2:0] rd_out,
  output logic       reg_write_out,
  output logic       mem_to_reg_out,
  output logic       timeout_err_out
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state_reg;
  logic   access;
  logic   read_pending_reg;
  logic   timeout_hit;

  assign access = mem_read_in | mem_write_in;

`ifdef MEM_TIMEOUT_EN
  logic [3:0] tmo_cnt_reg;
  logic       timeout_err_reg;

  assign timeout_hit     = (state_reg == BUSY) && !dmem_ack && (tmo_cnt_reg == 4'(TIMEOUT - 1));
  assign timeout_err_out = timeout_err_reg;

  // Held at zero in IDLE so it always starts from zero on entry to BUSY.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt_reg     <= 4'd0;
      timeout_err_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE) tmo_cnt_reg <= 4'd0;
      else                   tmo_cnt_reg <= tmo_cnt_reg + 4'd1;
      if (timeout_hit) timeout_err_reg <= 1'b1;
    end
  end
`else
  assign timeout_hit     = 1'b0;
  assign timeout_err_out = 1'b0;
`endif

  // A timed-out access leaves the stage as a bubble, so the front end may advance.
  always_comb begin
    stall_out = 1'b0;
    if (reset) begin
      case (state_reg)
        IDLE:    stall_out = access;
        BUSY:    stall_out = !dmem_ack && !timeout_hit;
        default: stall_out = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg        <= IDLE;
      read_pending_reg <= 1'b0;
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_addr        <= 8'd0;
      dmem_wdata       <= 8'd0;
      alu_result_out   <= 8'd0;
      read_data_out    <= 8'd0;
      rd_out           <= 3'd0;
      reg_write_out    <= 1'b0;
      mem_to_reg_out   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (access) begin
            dmem_req         <= 1'b1;
            dmem_we          <= mem_write_in;
            dmem_addr        <= alu_result_in;
            dmem_wdata       <= write_data_in;
            read_pending_reg <= mem_read_in & ~mem_write_in;
            reg_write_out    <= 1'b0;
            mem_to_reg_out   <= 1'b0;
            state_reg        <= BUSY;
          end else begin
            alu_result_out <= alu_result_in;
            read_data_out  <= 8'd0;
            rd_out         <= rd_in;
            reg_write_out  <= reg_write_in;
            mem_to_reg_out <= mem_to_reg_in;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            alu_result_out <= alu_result_in;
            read_data_out  <= read_pending_reg ? dmem_rdata : 8'd0;
            rd_out         <= rd_in;
            reg_write_out  <= reg_write_in;
            mem_to_reg_out <= mem_to_reg_in;
            state_reg      <= IDLE;
          end else if (timeout_hit) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            read_data_out  <= 8'd0;
            reg_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
            state_reg      <= IDLE;
          end else begin
            reg_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed plus randomized bench for mem_access_stage with a bus-level memory responder and a transaction model.
module tb_mem_access_stage;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] alu_result_in = '0, write_data_in = '0;
  logic [2:0] rd_in = '0;
  logic       mem_read_in = 0, mem_write_in = 0, reg_write_in = 0, mem_to_reg_in = 0;
  logic       stall_out, dmem_req, dmem_we;
  logic [7:0] dmem_addr, dmem_wdata;
  logic       dmem_ack = 0;
  logic [7:0] dmem_rdata = '0;
  logic [7:0] alu_result_out, read_data_out;
  logic [2:0] rd_out;
  logic       reg_write_out, mem_to_reg_out, timeout_err_out;

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in), .rd_in(rd_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_result_out(alu_result_out), .read_data_out(read_data_out), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .timeout_err_out(timeout_err_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int txn = 0;
  logic [7:0] mem_array [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_alu = '0, exp_rdata = '0;
  logic [2:0] exp_rd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check(tag, {reg_write_out, mem_to_reg_out, rd_out, alu_result_out, read_data_out},
          {1'b0, 1'b0, exp_rd, exp_alu, exp_rdata});
  endtask

  // One instruction through MEM; ack arrives after 'delay' BUSY cycles without it.
  task automatic do_op(input logic rd_op, input logic wr_op, input logic [7:0] alu,
                       input logic [7:0] wd, input logic [2:0] rd, input logic rw,
                       input logic m2r, input int delay);
    int   stalls;
    logic acc;
    stalls = 0;
    acc = rd_op | wr_op;
    mem_read_in = rd_op; mem_write_in = wr_op; alu_result_in = alu;
    write_data_in = wd; rd_in = rd; reg_write_in = rw; mem_to_reg_in = m2r;
    dmem_ack = 0;
    #1;
    check("stall_first", stall_out, acc);
    if (stall_out) stalls++;
    if (!acc) begin
      tick;
      exp_alu = alu; exp_rd = rd; exp_rdata = 8'h00;
      check("alu_retire",
            {reg_write_out, mem_to_reg_out, rd_out, alu_result_out, read_data_out, dmem_req, timeout_err_out},
            {rw, m2r, rd, alu, 8'h00, 1'b0, 1'b0});
    end else begin
      tick;
      check("req_issue", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, {1'b1, wr_op, alu, wd});
      check_bubble("bubble_issue");
      for (int i = 0; i < delay; i++) begin
        #1;
        check("stall_busy", stall_out, 1);
        if (stall_out) stalls++;
        tick;
        check("req_hold", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, {1'b1, wr_op, alu, wd});
        check_bubble("bubble_wait");
      end
      dmem_ack = 1;
      dmem_rdata = dmem_we ? 8'($urandom) : mem_array[dmem_addr];
      if (dmem_we) mem_array[dmem_addr] = dmem_wdata;
      #1;
      check("stall_ack", stall_out, 0);
      tick;
      dmem_ack = 0;
      exp_alu = alu; exp_rd = rd;
      exp_rdata = (rd_op && !wr_op) ? ref_mem[alu] : 8'h00;
      if (wr_op) ref_mem[alu] = wd;
      check("mem_retire", {reg_write_out, mem_to_reg_out, rd_out, alu_result_out, read_data_out, dmem_req},
            {rw, m2r, rd, alu, exp_rdata, 1'b0});
      check("stall_cycles", 32'(stalls), 32'(delay + 1));
    end
    txn++;
    $display("txn %0d rd=%0b wr=%0b addr=%02h wdata=%02h rd_reg=%0d delay=%0d rdata_out=%02h",
             txn, rd_op, wr_op, alu, wd, rd, delay, read_data_out);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_array[i] = 8'($urandom);
      ref_mem[i] = mem_array[i];
    end
    mem_array[8'h10] = 8'hA5;
    ref_mem[8'h10] = 8'hA5;

    // Reset held for two cycles with an access pending and ack toggling.
    reset = 0; mem_read_in = 1; alu_result_in = 8'h99; rd_in = 3'd6; reg_write_in = 1;
    for (int i = 0; i < 2; i++) begin
      dmem_ack = ~dmem_ack;
      #1;
      check("reset_stall", stall_out, 0);
      tick;
      check("reset_outs",
            {dmem_req, dmem_we, dmem_addr, dmem_wdata, alu_result_out, read_data_out, rd_out,
             reg_write_out, mem_to_reg_out, timeout_err_out}, 0);
    end
    dmem_ack = 0;
    reset = 1;

    do_op(0, 0, 8'h3C, 8'h00, 3'd5, 1, 0, 0);   // plain ALU op
    do_op(1, 0, 8'h10, 8'h00, 3'd2, 1, 1, 3);   // load with three wait cycles
    do_op(0, 1, 8'h20, 8'h77, 3'd0, 0, 0, 0);   // store, then load immediately after
    do_op(1, 0, 8'h21, 8'h00, 3'd3, 1, 1, 0);
    do_op(1, 0, 8'h20, 8'h00, 3'd4, 1, 1, 0);   // read back the stored byte
    do_op(1, 1, 8'h30, 8'h5A, 3'd1, 0, 0, 1);   // read+write acts as write

    // Reset taken while BUSY abandons the access.
    mem_read_in = 1; mem_write_in = 0; alu_result_in = 8'h44; rd_in = 3'd7;
    reg_write_in = 1; mem_to_reg_in = 1;
    #1;
    tick;
    check("busy_req", dmem_req, 1);
    reset = 0;
    #1;
    check("busy_reset_stall", stall_out, 0);
    tick;
    check("busy_reset_outs",
          {dmem_req, alu_result_out, read_data_out, rd_out, reg_write_out, mem_to_reg_out}, 0);
    exp_alu = 0; exp_rd = 0; exp_rdata = 0;
    reset = 1;
    // Stray ack in IDLE is ignored; an ALU op retires in one edge.
    mem_read_in = 0; alu_result_in = 8'hE1; rd_in = 3'd2; reg_write_in = 1; mem_to_reg_in = 0;
    dmem_ack = 1;
    #1;
    check("idle_ack_stall", stall_out, 0);
    tick;
    dmem_ack = 0;
    check("idle_after_reset", {dmem_req, reg_write_out, rd_out, alu_result_out}, {1'b0, 1'b1, 3'd2, 8'hE1});
    exp_alu = 8'hE1; exp_rd = 3'd2;

    // Randomized traffic over a small address window to force reuse.
    for (int n = 0; n < 40; n++) begin
      int kind;
      logic [7:0] a;
      kind = int'($urandom_range(0, 3));
      a = 8'h40 + 8'($urandom_range(0, 7));
      case (kind)
        0: do_op(0, 0, 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 0, 0);
        1: do_op(1, 0, a, 8'($urandom), 3'($urandom), 1, 1, int'($urandom_range(0, 4)));
        2: do_op(0, 1, a, 8'($urandom), 3'($urandom), 0, 0, int'($urandom_range(0, 4)));
        default: do_op(1, 1, a, 8'($urandom), 3'($urandom), 0, 0, int'($urandom_range(0, 4)));
      endcase
    end

`ifdef MEM_TIMEOUT_EN
    begin
      int reqs;
      reqs = 0;
      mem_read_in = 1; mem_write_in = 0; alu_result_in = 8'h55; rd_in = 3'd1;
      reg_write_in = 1; mem_to_reg_in = 1; dmem_ack = 0;
      #1;
      tick;
      for (int i = 0; i < 40 && dmem_req; i++) begin
        reqs++;
        tick;
      end
      check("timeout_len", 32'(reqs), 32'(TIMEOUT));
      exp_rdata = 8'h00;
      check("timeout_flag", timeout_err_out, 1);
      check_bubble("timeout_bubble");
      mem_read_in = 0; reg_write_in = 0;
      tick;
      tick;
      check("timeout_sticky", timeout_err_out, 1);
      reset = 0;
      tick;
      reset = 1;
      check("timeout_cleared", timeout_err_out, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
